// File: rtl/snn_ctrl_pkg.sv
// Shared definitions for the SNN pooling-layer run controller.
package snn_ctrl_pkg;

   // Default widths for timestep/window counters and the drain timeout counter.
   localparam int TS_W_DEF = 16;
   localparam int TO_W_DEF = 16;

   // Number of leading DRAIN cycles in which layer_done is treated as stale.
   localparam logic [1:0] DRAIN_GUARD = 2'd2;

   // Controller state encoding.
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_ACCEPT = 3'd1,
      ST_FLUSH  = 3'd2,
      ST_DRAIN  = 3'd3,
      ST_FIN    = 3'd4
   } snn_state_e;

endpackage

// File: rtl/snn_window_timer.sv
// Saturating up-counter with a synchronous clear and an equality expire flag.
// Used both for the ACCEPT window and for the DRAIN timeout.
module snn_window_timer #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic         enable,
   input  logic [W-1:0] limit,
   output logic         expire
);

   logic [W-1:0] count;

   // Count up while enabled; load clears to zero and wins over enable.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (load) begin
         count <= '0;
      end else if (enable && (count != '1)) begin
         count <= count + W'(1);
      end
   end

   assign expire = (count == limit);

endmodule

// File: rtl/snn_pool_sched.sv
// Run controller for one SNN pooling layer: opens an input window per
// timestep, flushes the pooled output, waits for the layer to finish and
// repeats for cfg_num_ts timesteps.
//
// Interface semantics: in_tlast_hs is already the qualified upstream
// tvalid&tready&tlast beat; it is only acted upon in ACCEPT. layer_in_gate is
// ANDed by the layer wrapper into its own tvalid/tready, so no beat can
// transfer while it is low.
module snn_pool_sched
   import snn_ctrl_pkg::*;
#(
   parameter int TS_W = TS_W_DEF,
   parameter int TO_W = TO_W_DEF
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic            abort,
   input  logic [TS_W-1:0] cfg_num_ts,
   input  logic [TS_W-1:0] cfg_window,
   input  logic [TO_W-1:0] cfg_drain_to,
   input  logic            in_tlast_hs,
   input  logic            layer_done,
   output logic            layer_enable,
   output logic            layer_in_gate,
   output logic            layer_flush,
   output logic            busy,
   output logic            done,
   output logic            aborted,
   output logic            timeout_err,
   output logic [TS_W-1:0] cur_ts,
   output logic [31:0]     run_cycles,
   output snn_state_e      state_dbg
);

   logic            rst_meta, rst_sync;
   snn_state_e      state, state_nx;
   logic [TS_W-1:0] num_ts_r, window_r;
   logic [TO_W-1:0] drain_to_r;
   logic            win_exp, dr_exp;
   logic [1:0]      guard_cnt;
   logic            go, ts_inc, to_set;
   logic            enable_d, gate_d, flush_d, busy_d, done_d, aborted_d;

   // Reset asserts immediately and releases two clock edges later.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rst_meta <= 1'b1;
         rst_sync <= 1'b1;
      end else begin
         rst_meta <= 1'b0;
         rst_sync <= rst_meta;
      end
   end

   assign go        = (state == ST_IDLE) && start && !abort;
   assign state_dbg = state;

   snn_window_timer #(.W(TS_W)) u_win_timer (
      .clk    (clk),
      .reset  (rst_sync),
      .load   (state != ST_ACCEPT),
      .enable (state == ST_ACCEPT),
      .limit  (window_r - TS_W'(1)),
      .expire (win_exp)
   );

   snn_window_timer #(.W(TO_W)) u_drain_timer (
      .clk    (clk),
      .reset  (rst_sync),
      .load   (state != ST_DRAIN),
      .enable (state == ST_DRAIN),
      .limit  (drain_to_r),
      .expire (dr_exp)
   );

   // Counts the first DRAIN cycles so a stale layer_done is not honoured.
   always_ff @(posedge clk or posedge rst_sync) begin
      if (rst_sync)                  guard_cnt <= 2'd0;
      else if (state != ST_DRAIN)    guard_cnt <= 2'd0;
      else if (guard_cnt != DRAIN_GUARD) guard_cnt <= guard_cnt + 2'd1;
   end

   // State register.
   always_ff @(posedge clk or posedge rst_sync) begin
      if (rst_sync) state <= ST_IDLE;
      else          state <= state_nx;
   end

   // Next-state logic; abort outranks every other transition.
   always_comb begin
      state_nx = state;
      ts_inc   = 1'b0;
      to_set   = 1'b0;
      if ((state != ST_IDLE) && abort) begin
         state_nx = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: begin
               if (go) state_nx = (cfg_num_ts == '0) ? ST_FIN : ST_ACCEPT;
            end
            ST_ACCEPT: begin
               if (in_tlast_hs || ((window_r != '0) && win_exp)) state_nx = ST_FLUSH;
            end
            ST_FLUSH: state_nx = ST_DRAIN;
            ST_DRAIN: begin
               if (layer_done && (guard_cnt == DRAIN_GUARD)) begin
                  if (cur_ts == num_ts_r - TS_W'(1)) begin
                     state_nx = ST_FIN;
                  end else begin
                     state_nx = ST_ACCEPT;
                     ts_inc   = 1'b1;
                  end
               end else if ((drain_to_r != '0) && dr_exp) begin
                  state_nx = ST_FIN;
                  to_set   = 1'b1;
               end
            end
            ST_FIN:  state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
         endcase
      end
   end

   // Output decode from the next state so every output is a flop.
   always_comb begin
      busy_d    = (state_nx != ST_IDLE);
      enable_d  = (state_nx == ST_ACCEPT) || (state_nx == ST_FLUSH) || (state_nx == ST_DRAIN);
      gate_d    = (state_nx == ST_ACCEPT);
      flush_d   = (state_nx == ST_FLUSH);
      done_d    = (state_nx == ST_FIN);
      aborted_d = (state != ST_IDLE) && abort;
   end

   // Output registers.
   always_ff @(posedge clk or posedge rst_sync) begin
      if (rst_sync) begin
         layer_enable  <= 1'b0;
         layer_in_gate <= 1'b0;
         layer_flush   <= 1'b0;
         busy          <= 1'b0;
         done          <= 1'b0;
         aborted       <= 1'b0;
      end else begin
         layer_enable  <= enable_d;
         layer_in_gate <= gate_d;
         layer_flush   <= flush_d;
         busy          <= busy_d;
         done          <= done_d;
         aborted       <= aborted_d;
      end
   end

   // Run configuration, timestep index, timeout flag and run cycle counter.
   always_ff @(posedge clk or posedge rst_sync) begin
      if (rst_sync) begin
         num_ts_r    <= '0;
         window_r    <= '0;
         drain_to_r  <= '0;
         cur_ts      <= '0;
         timeout_err <= 1'b0;
         run_cycles  <= '0;
      end else if (go) begin
         num_ts_r    <= cfg_num_ts;
         window_r    <= cfg_window;
         drain_to_r  <= cfg_drain_to;
         cur_ts      <= '0;
         timeout_err <= 1'b0;
         run_cycles  <= '0;
      end else begin
         if (ts_inc) cur_ts <= cur_ts + TS_W'(1);
         if (to_set) timeout_err <= 1'b1;
         if ((state != ST_IDLE) && (run_cycles != 32'hFFFF_FFFF)) run_cycles <= run_cycles + 32'd1;
      end
   end

endmodule
